// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer between the MEM pipeline stage and a
// single-port data memory using a valid/ready handshake.
//
// Stores get byte enables and lane-replicated write data. Loads capture the
// returned word, shift the addressed lane down and sign/zero-extend it
// according to funct3 (B/H/W/BU/HU). The pipeline is stalled for the whole
// access. Misaligned, illegal-funct3 and timed-out accesses complete with
// rsp_fault set.
//
// Optional feature macro: LSU_MISALIGN_TRAP_EN
//   defined   : misaligned H/HU/W accesses complete with a fault and never
//               reach memory
//   undefined : the byte offset is forced aligned (H: offset[0]=0, W: 0) and
//               the access is issued normally
//
// Parameters:
//   TIMEOUT     max cycles spent in REQ or RSP before the access is aborted
//
// Ports:
//   clk, rst_n          clock (rising edge), async active-low reset
//   req_valid/req_ready request handshake from/to the MEM stage
//   req_we, req_funct3  access type and size
//   req_addr, req_wdata byte address and right-aligned store data
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata           extended load data (0 for stores and faults)
//   rsp_fault           misaligned / illegal / timeout, valid with rsp_valid
//   stall               pipeline freeze: req_valid & ~rsp_valid
//   mem_valid/mem_ready memory request handshake
//   mem_we, mem_addr    write strobe and word address
//   mem_be, mem_wdata   byte enables and lane-replicated store data
//   mem_rvalid          read data valid
//   mem_rdata           raw read word
module lsu_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_fault,
    output logic        stall,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // The counter value seen in the last cycle allowed in REQ or RSP.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [1:0]        offset_q, offset_d;

    logic              mem_valid_q, mem_valid_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;

    // Request decode helpers (only meaningful while IDLE with req_valid).
    logic              illegal;
    logic              misaligned;
    logic [1:0]        eff_offset;

    // Load data alignment helpers.
    logic [31:0]       shifted;
    logic [31:0]       load_ext;

    // Decode the incoming request: legality, alignment and the byte offset
    // that will actually be used for lanes and load shifting.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        eff_offset = req_addr[1:0];

        if (req_we) begin
            illegal = !(req_funct3 == 3'b000 || req_funct3 == 3'b001 ||
                        req_funct3 == 3'b010);
        end else begin
            illegal = (req_funct3 == 3'b011 || req_funct3 == 3'b110 ||
                       req_funct3 == 3'b111);
        end

`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'b01) begin
            misaligned = req_addr[0];
        end else if (req_funct3[1:0] == 2'b10) begin
            misaligned = (req_addr[1:0] != 2'b00);
        end
`else
        // No trap: drop the low offset bits so the access becomes aligned.
        if (req_funct3[1:0] == 2'b01) begin
            eff_offset = {req_addr[1], 1'b0};
        end else if (req_funct3[1:0] == 2'b10) begin
            eff_offset = 2'b00;
        end
`endif
    end

    // Move the addressed lane down to bit 0 and extend it per funct3.
    always_comb begin
        shifted  = mem_rdata >> {offset_q, 3'b000};
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = shifted;
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = 32'd0;
        endcase
    end

    // State and registered outputs. Reset mid-access clears mem_valid at
    // once and discards the access without any response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            offset_q    <= 2'b00;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            offset_q    <= offset_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    // Next-state and next-output logic. rsp_valid/rsp_fault default low so
    // the completion pulse lasts exactly the one DONE cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        offset_d    = offset_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = 1'b0;
        rsp_fault_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    offset_d = eff_offset;
                    if (illegal || misaligned) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_fault_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_valid_d = 1'b1;
                        mem_we_d    = req_we;
                        mem_addr_d  = {req_addr[31:2], 2'b00};
                        mem_be_d    = 4'b1111;
                        mem_wdata_d = req_wdata;
                        if (req_we) begin
                            if (req_funct3[1:0] == 2'b00) begin
                                mem_be_d    = 4'b0001 << eff_offset;
                                mem_wdata_d = {4{req_wdata[7:0]}};
                            end else if (req_funct3[1:0] == 2'b01) begin
                                mem_be_d    = 4'b0011 << eff_offset;
                                mem_wdata_d = {2{req_wdata[15:0]}};
                            end
                        end
                    end
                end
            end

            S_REQ: begin
                // A handshake wins over the timeout in the same cycle; any
                // mem_rvalid seen here is not looked at.
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    if (we_q) begin
                        state_d     = S_DONE;
                        rsp_valid_d = 1'b1;
                        rsp_rdata_d = 32'd0;
                    end else begin
                        state_d = S_RSP;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_valid_d = 1'b0;
                    mem_we_d    = 1'b0;
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_RSP: begin
                if (mem_rvalid) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_ext;
                end else if (cnt_q == CNT_LAST) begin
                    state_d     = S_DONE;
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_ready = (state_q == S_IDLE);
    assign stall     = req_valid & ~rsp_valid_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_fault = rsp_fault_q;
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule
